// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and saturating bubble/flush counters.
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter int SKID       = 1,
    parameter int FLUSH_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        flush_n;
    logic [SW-1:0]     flush_sum;

    assign in_ready  = (SKID != 0) ? !skid_valid_q : (!valid_q || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;
    assign flush_n   = {1'b0, valid_q} + {1'b0, skid_valid_q} + {1'b0, in_xfer};
    assign flush_sum = {2'b00, flush_cnt_q} + SW'(flush_n);

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            if (FLUSH_DATA != 0) begin
                data_d      = '0;
                skid_data_d = '0;
            end
        end else if (SKID == 0) begin
            if (in_xfer) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
        end else if (skid_valid_q) begin
            // FULL: in_ready is low, only the drain path can move.
            if (out_xfer) begin
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (valid_q) begin
            if (in_xfer && out_xfer) begin
                ctrl_d = in_ctrl;
                data_d = in_data;
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!valid_q && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
        if (flush) begin
            flush_cnt_d = (flush_sum > CNT_MAX) ? {CNT_W{1'b1}}
                                                : flush_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_ctrl   = valid_q ? ctrl_q : '0;
    assign out_data   = data_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid build and a single-register build share
// stimulus and are each compared against a queue model of the stage.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [NW-1:0] bubble0, flush0, bubble1, flush1;

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(1), .FLUSH_DATA(0), .CNT_W(NW)
    ) u_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0),
        .bubble_cnt(bubble0), .flush_cnt(flush0)
    );

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(0), .FLUSH_DATA(1), .CNT_W(NW)
    ) u_flat (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1),
        .bubble_cnt(bubble1), .flush_cnt(flush1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    // Model: index 0 = capacity-2 skid stage, index 1 = capacity-1 stage.
    ent_t          mq[2][2];
    int            sz[2];
    logic [DW-1:0] ld[2];
    int            bc[2];
    int            fc[2];

    function automatic bit mrdy(int k);
        if (k == 0) return sz[0] < 2;
        return (sz[1] == 0) || out_ready;
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic          v, r;
            logic [CW-1:0] c;
            logic [DW-1:0] d;
            logic [NW-1:0] b, f;
            v = (k == 0) ? out_valid0 : out_valid1;
            r = (k == 0) ? in_ready0  : in_ready1;
            c = (k == 0) ? out_ctrl0  : out_ctrl1;
            d = (k == 0) ? out_data0  : out_data1;
            b = (k == 0) ? bubble0    : bubble1;
            f = (k == 0) ? flush0     : flush1;
            chk($sformatf("k%0d out_valid", k), 64'(v), 64'(sz[k] > 0));
            chk($sformatf("k%0d in_ready", k), 64'(r), 64'(mrdy(k)));
            chk($sformatf("k%0d out_ctrl", k), 64'(c),
                64'((sz[k] > 0) ? mq[k][0].c : '0));
            chk($sformatf("k%0d out_data", k), 64'(d), 64'(ld[k]));
            chk($sformatf("k%0d bubble_cnt", k), 64'(b), 64'(bc[k]));
            chk($sformatf("k%0d flush_cnt", k), 64'(f), 64'(fc[k]));
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit acc, outx;
            acc  = in_valid && mrdy(k);
            outx = (sz[k] > 0) && out_ready;
            if (sz[k] == 0 && out_ready) bc[k] = (bc[k] + 1 > MAXC) ? MAXC : bc[k] + 1;
            if (flush) begin
                fc[k] = fc[k] + sz[k] + int'(acc);
                if (fc[k] > MAXC) fc[k] = MAXC;
                sz[k] = 0;
                if (k == 1) ld[k] = '0;
            end else begin
                if (outx) begin
                    mq[k][0] = mq[k][1];
                    sz[k]--;
                end
                if (acc) begin
                    mq[k][sz[k]] = '{c: in_ctrl, d: in_data};
                    sz[k]++;
                end
            end
            if (sz[k] > 0) ld[k] = mq[k][0].d;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            sz[k] = 0;
            ld[k] = '0;
            bc[k] = 0;
            fc[k] = 0;
            mq[k][0] = '0;
            mq[k][1] = '0;
        end
    endtask

    task automatic setin(bit v, logic [CW-1:0] c, logic [DW-1:0] d, bit r, bit f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Async reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        mreset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
    endtask

    initial begin
        reset_n = 1'b0;
        setin(0, '0, '0, 1, 0);
        mreset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all();

        for (int i = 1; i <= 8; i++) begin
            setin(1, CW'(i), DW'(i), 1, 0);
            step();
        end
        setin(0, '0, '0, 1, 0);
        step();

        do_reset();
        setin(1, 8'h11, 32'hAAAA_0001, 0, 0);
        step();
        setin(1, 8'h22, 32'hBBBB_0002, 0, 0);
        step();
        setin(0, '0, '0, 0, 0);
        step();
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        do_reset();
        setin(1, 8'h33, 32'hCCCC_0003, 0, 0);
        step();
        setin(1, 8'h44, 32'hDDDD_0004, 0, 0);
        step();
        setin(1, 8'h55, 32'hEEEE_0005, 0, 1);
        step();
        setin(0, '0, '0, 1, 0);
        step();

        do_reset();
        setin(1, 8'h66, 32'h1234_5678, 1, 1);
        step();
        setin(0, '0, '0, 1, 0);
        step();

        do_reset();
        setin(0, '0, '0, 1, 0);
        for (int i = 0; i < 20; i++) step();

        setin(1, 8'h77, 32'h0000_0077, 0, 0);
        step();
        setin(1, 8'h88, 32'h0000_0088, 0, 0);
        step();
        setin(0, '0, '0, 0, 0);
        do_reset();
        setin(1, 8'h99, 32'h0000_0099, 1, 0);
        step();

        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) do_reset();
            setin(($urandom % 4) != 0, CW'($urandom), DW'($urandom),
                  ($urandom % 3) != 0, ($urandom % 16) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
